// File: rtl/iic_pkg.sv
// Shared types and constants for the PMIC I2C write sequencer.
package iic_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_U_START,
      S_U_WAIT,
      S_W_START,
      S_W_WAIT,
      S_GAP
   } state_e;

   localparam logic [7:0] REG_VOUT        = 8'h00;
   localparam logic [7:0] REG_LOCK        = 8'h01;
   localparam logic [7:0] UNLOCK_ADDR_DEF = REG_LOCK;
   localparam logic [7:0] UNLOCK_DATA_DEF = 8'hE0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr_q upward, pointer moves past the winner on en_i.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [NREQ-1:0] req_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             found;

   // First pass covers ptr..NREQ-1, second pass wraps around to 0..ptr-1.
   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_i[i] && (i >= int'(ptr_q))) begin
            found    = 1'b1;
            gnt_o[i] = 1'b1;
            ptr_d    = (i == NREQ - 1) ? '0 : IDX_W'(i + 1);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_i[i]) begin
            found    = 1'b1;
            gnt_o[i] = 1'b1;
            ptr_d    = (i == NREQ - 1) ? '0 : IDX_W'(i + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q <= '0;
      end else if (en_i) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/iic_write_sched.sv
// Arbitrated sequencer driving one PMIC I2C master: optional unlock write, target write,
// bus-free gap, and per-requester done/err reporting with a finish timeout.
module iic_write_sched
   import iic_pkg::*;
#(
   parameter int         NREQ        = 2,
   parameter logic [7:0] UNLOCK_ADDR = UNLOCK_ADDR_DEF,
   parameter logic [7:0] UNLOCK_DATA = UNLOCK_DATA_DEF,
   parameter int         TIMEOUT_CYC = 500000,
   parameter int         GAP_CYC     = 100
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_addr,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_unlock,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   done,
   output logic [NREQ-1:0]   err,
   output logic              busy,
   output logic              m_start,
   output logic [7:0]        m_reg_addr,
   output logic [7:0]        m_data,
   output logic              m_abort,
   input  logic              m_finish
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(GAP_CYC - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   state_e           state_q, ret_q;
   logic [NREQ-1:0]  gnt_q, arb_gnt, ready_q, done_q, err_q;
   logic [7:0]       addr_q, data_q, m_reg_addr_q, m_data_q, sel_addr, sel_data;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q, m_start_q, m_abort_q, sel_unlock, arb_en;

   assign arb_en = (state_q == S_IDLE) && (|req_valid);

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk   (clk),
      .rstn  (rstn),
      .req_i (req_valid),
      .en_i  (arb_en),
      .gnt_o (arb_gnt)
   );

   always_comb begin
      sel_addr   = 8'h00;
      sel_data   = 8'h00;
      sel_unlock = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_q[i]) begin
            sel_addr   = req_addr[8*i +: 8];
            sel_data   = req_data[8*i +: 8];
            sel_unlock = req_unlock[i];
         end
      end
   end

   // cnt_q times both the finish timeout (counted from the start cycle) and the bus-free gap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         ret_q        <= S_IDLE;
         gnt_q        <= '0;
         ready_q      <= '0;
         done_q       <= '0;
         err_q        <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         m_reg_addr_q <= '0;
         m_data_q     <= '0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         m_start_q    <= 1'b0;
         m_abort_q    <= 1'b0;
      end else begin
         ready_q   <= '0;
         done_q    <= '0;
         err_q     <= '0;
         m_start_q <= 1'b0;
         m_abort_q <= 1'b0;
         if ((|done_q) || (|err_q)) busy_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (arb_en) begin
                  gnt_q   <= arb_gnt;
                  ready_q <= arb_gnt;
                  busy_q  <= 1'b1;
                  state_q <= S_ARB;
               end
            end
            S_ARB: begin
               addr_q    <= sel_addr;
               data_q    <= sel_data;
               cnt_q     <= '0;
               m_start_q <= 1'b1;
               if (sel_unlock) begin
                  m_reg_addr_q <= UNLOCK_ADDR;
                  m_data_q     <= UNLOCK_DATA;
                  state_q      <= S_U_START;
               end else begin
                  m_reg_addr_q <= sel_addr;
                  m_data_q     <= sel_data;
                  state_q      <= S_W_START;
               end
            end
            S_U_START, S_W_START: begin
               cnt_q   <= sat_inc(cnt_q);
               state_q <= (state_q == S_U_START) ? S_U_WAIT : S_W_WAIT;
            end
            S_U_WAIT, S_W_WAIT: begin
               if (m_finish) begin
                  cnt_q   <= '0;
                  state_q <= S_GAP;
                  if (state_q == S_U_WAIT) begin
                     ret_q <= S_W_START;
                  end else begin
                     ret_q  <= S_IDLE;
                     done_q <= gnt_q;
                  end
               end else if (cnt_q == CNT_TERM) begin
                  cnt_q     <= '0;
                  m_abort_q <= 1'b1;
                  err_q     <= gnt_q;
                  ret_q     <= S_IDLE;
                  state_q   <= S_GAP;
               end else begin
                  cnt_q <= sat_inc(cnt_q);
               end
            end
            S_GAP: begin
               if (cnt_q == GAP_TERM) begin
                  cnt_q   <= '0;
                  state_q <= ret_q;
                  if (ret_q == S_W_START) begin
                     m_start_q    <= 1'b1;
                     m_reg_addr_q <= addr_q;
                     m_data_q     <= data_q;
                  end
               end else begin
                  cnt_q <= sat_inc(cnt_q);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign done       = done_q;
   assign err        = err_q;
   assign busy       = busy_q;
   assign m_start    = m_start_q;
   assign m_reg_addr = m_reg_addr_q;
   assign m_data     = m_data_q;
   assign m_abort    = m_abort_q;

endmodule

// File: tb/tb_iic_write_sched.sv
// Directed bench for iic_write_sched: unlock/target sequencing, round-robin order, timeout and reset.
module tb_iic_write_sched;
   import iic_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  req_valid, req_unlock, req_ready, done, err;
   logic [15:0] req_addr, req_data;
   logic        busy, m_start, m_abort, m_finish;
   logic [7:0]  m_reg_addr, m_data;
   int          ncmp = 0;
   int          nfail = 0;
   int          n, s, d, e, s2;

   iic_write_sched #(
      .NREQ(2), .UNLOCK_ADDR(8'h01), .UNLOCK_DATA(8'hE0), .TIMEOUT_CYC(1000), .GAP_CYC(100)
   ) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_unlock(req_unlock), .req_ready(req_ready), .done(done), .err(err), .busy(busy),
      .m_start(m_start), .m_reg_addr(m_reg_addr), .m_data(m_data), .m_abort(m_abort),
      .m_finish(m_finish)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag, input logic [1:0] exp);
      int k;
      k = 0;
      while (req_ready === 2'b00 && k < 400) begin
         tick();
         k++;
      end
      chk(tag, req_ready, exp);
   endtask

   task automatic finish_pulse();
      m_finish = 1'b1;
      tick();
      m_finish = 1'b0;
   endtask

   task automatic watch(input int cyc, output int ns, output int nd, output int ne);
      ns = 0; nd = 0; ne = 0;
      for (int i = 0; i < cyc; i++) begin
         tick();
         if (m_start === 1'b1) ns++;
         if (done !== 2'b00) nd++;
         if (err !== 2'b00) ne++;
      end
   endtask

   initial begin
      rstn = 1'b0; req_valid = '0; req_unlock = '0; req_addr = '0; req_data = '0; m_finish = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", {req_ready, done, err, busy, m_start, m_reg_addr, m_data, m_abort}, 32'h0);
      rstn = 1'b1;
      tick();
      chk("idle_busy", busy, 1'b0);

      // unlock then target write for requester 0
      req_addr[7:0] = REG_VOUT; req_data[7:0] = 8'h5A; req_unlock = 2'b01; req_valid = 2'b01;
      wait_ready("t1_ready", 2'b01);
      chk("t1_busy", busy, 1'b1);
      tick();
      chk("t1_ustart", {m_start, m_reg_addr, m_data}, {1'b1, 8'h01, 8'hE0});
      req_valid = '0; req_addr = 16'hFFFF; req_data = 16'hFFFF; req_unlock = '0;
      tick();
      chk("t1_start_pulse", m_start, 1'b0);
      repeat (298) tick();
      finish_pulse();
      n = 0;
      while (m_start !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("t1_gap_len", n, 100);
      chk("t1_wstart", {m_reg_addr, m_data}, {8'h00, 8'h5A});
      repeat (20) tick();
      finish_pulse();
      chk("t1_done", {done, err, busy}, {2'b01, 2'b00, 1'b1});
      tick();
      chk("t1_after", {done, busy}, 3'b000);
      finish_pulse();
      chk("t1_stray_done", done, 2'b00);
      watch(150, s, d, e);
      chk("t1_stray_quiet", s + d + e, 0);

      // no-unlock write for requester 1
      req_addr = 16'h0300; req_data = 16'h1100; req_unlock = 2'b00; req_valid = 2'b10;
      wait_ready("t2_ready", 2'b10);
      tick();
      chk("t2_wstart", {m_start, m_reg_addr, m_data}, {1'b1, 8'h03, 8'h11});
      req_valid = '0;
      watch(5, s, d, e);
      finish_pulse();
      chk("t2_done", done, 2'b10);
      watch(150, s2, d, e);
      chk("t2_one_start", s + s2, 0);

      // round-robin order 0,1,0 after a fresh reset
      rstn = 1'b0; tick(); rstn = 1'b1; tick();
      req_addr = {8'h21, 8'h10}; req_data = {8'hB1, 8'hA0}; req_unlock = 2'b00; req_valid = 2'b11;
      wait_ready("t3_ready_a", 2'b01);
      tick();
      chk("t3_start_a", {m_start, m_reg_addr, m_data}, {1'b1, 8'h10, 8'hA0});
      req_valid[0] = 1'b0;
      watch(3, s, d, e);
      finish_pulse();
      chk("t3_done_a", done, 2'b01);
      req_valid[0] = 1'b1; req_addr[7:0] = 8'h12; req_data[7:0] = 8'hA2;
      wait_ready("t3_ready_b", 2'b10);
      tick();
      chk("t3_start_b", {m_start, m_reg_addr, m_data}, {1'b1, 8'h21, 8'hB1});
      req_valid[1] = 1'b0;
      watch(3, s, d, e);
      finish_pulse();
      chk("t3_done_b", done, 2'b10);
      wait_ready("t3_ready_c", 2'b01);
      tick();
      chk("t3_start_c", {m_start, m_reg_addr, m_data}, {1'b1, 8'h12, 8'hA2});
      req_valid = '0;
      watch(3, s, d, e);
      finish_pulse();
      chk("t3_done_c", done, 2'b01);
      watch(150, s, d, e);

      // timeout on the unlock write
      req_addr[7:0] = 8'h00; req_data[7:0] = 8'h77; req_unlock = 2'b01; req_valid = 2'b01;
      wait_ready("t4_ready", 2'b01);
      tick();
      chk("t4_ustart", {m_start, m_reg_addr}, {1'b1, 8'h01});
      req_valid = '0; req_unlock = '0;
      n = 0;
      while (m_abort !== 1'b1 && n < 1100) begin
         tick();
         n++;
      end
      chk("t4_abort_cycle", n, 1000);
      chk("t4_err", {err, done}, {2'b01, 2'b00});
      tick();
      chk("t4_pulse_end", {m_abort, err, busy}, 4'b0000);
      watch(150, s, d, e);
      chk("t4_no_target", s + d + e, 0);

      // finish on the timeout terminal count
      req_addr[15:8] = 8'h04; req_data[15:8] = 8'h44; req_valid = 2'b10;
      wait_ready("t5_ready", 2'b10);
      tick();
      chk("t5_wstart", {m_start, m_reg_addr, m_data}, {1'b1, 8'h04, 8'h44});
      req_valid = '0;
      repeat (999) tick();
      finish_pulse();
      chk("t5_coincident", {done, err, m_abort}, {2'b10, 2'b00, 1'b0});
      watch(150, s, d, e);
      chk("t5_no_err", e, 0);

      // reset during W_WAIT
      req_addr[7:0] = 8'h05; req_data[7:0] = 8'h55; req_valid = 2'b01;
      wait_ready("t6_ready", 2'b01);
      tick();
      chk("t6_wstart", {m_start, m_reg_addr, m_data}, {1'b1, 8'h05, 8'h55});
      req_valid = '0;
      repeat (10) tick();
      rstn = 1'b0;
      #1;
      chk("t6_reset_now", {req_ready, done, err, busy, m_start, m_reg_addr, m_data, m_abort}, 32'h0);
      repeat (2) tick();
      rstn = 1'b1;
      finish_pulse();
      watch(50, s, d, e);
      chk("t6_no_report", s + d + e, 0);
      req_addr[15:8] = 8'h06; req_data[15:8] = 8'h66; req_valid = 2'b10;
      wait_ready("t6_ready2", 2'b10);
      tick();
      chk("t6_wstart2", {m_start, m_reg_addr, m_data}, {1'b1, 8'h06, 8'h66});
      req_valid = '0;
      watch(4, s, d, e);
      finish_pulse();
      chk("t6_done2", {done, err}, {2'b10, 2'b00});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
